// File: rtl/arf_rat_pkg.sv
// Shared types and sizes for the architectural register file / register alias table.
// Contents: register/ROB/data widths, the RAT entry layout, and the source lookup result.
package arf_rat_pkg;

    localparam int N_ARF          = 32;
    localparam int ARF_ID_WIDTH   = 5;
    localparam int ROB_ID_WIDTH   = 5;
    localparam int REG_DATA_WIDTH = 32;

    typedef logic [ARF_ID_WIDTH-1:0]   arf_id_t;
    typedef logic [ROB_ID_WIDTH-1:0]   rob_id_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    typedef struct packed {
        logic    renamed;
        rob_id_t rob_id;
    } rat_entry_t;

    typedef struct packed {
        logic      renamed;
        rob_id_t   rob_id;
        reg_data_t data;
    } src_lookup_t;

endpackage

// File: rtl/arf_rat_if.sv
// Bus between dispatch/ROB (master) and the ARF/RAT block (slave).
// Carries the dispatch rename request, two source lookups with their results,
// the ROB retire write and the mispredict flush.
interface arf_rat_if;
    import arf_rat_pkg::*;

    logic      dispatch_fire;
    logic      dispatch_dst_valid;
    arf_id_t   dispatch_dst_arf_id;
    rob_id_t   dispatch_rob_id;

    arf_id_t   src1_arf_id;
    arf_id_t   src2_arf_id;
    logic      src1_renamed;
    logic      src2_renamed;
    rob_id_t   src1_rob_id;
    rob_id_t   src2_rob_id;
    reg_data_t src1_reg_data;
    reg_data_t src2_reg_data;

    logic      retire;
    rob_id_t   retire_rob_id;
    arf_id_t   retire_arf_id;
    reg_data_t retire_reg_data;
    logic      retire_redirect_pc_valid;

    modport master (
        output dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
        output src1_arf_id, src2_arf_id,
        input  src1_renamed, src2_renamed, src1_rob_id, src2_rob_id,
        input  src1_reg_data, src2_reg_data,
        output retire, retire_rob_id, retire_arf_id, retire_reg_data,
        output retire_redirect_pc_valid
    );

    modport slave (
        input  dispatch_fire, dispatch_dst_valid, dispatch_dst_arf_id, dispatch_rob_id,
        input  src1_arf_id, src2_arf_id,
        output src1_renamed, src2_renamed, src1_rob_id, src2_rob_id,
        output src1_reg_data, src2_reg_data,
        input  retire, retire_rob_id, retire_arf_id, retire_reg_data,
        input  retire_redirect_pc_valid
    );

endinterface

// File: rtl/arf_rat_entry.sv
// One architectural register: committed data flop plus its RAT entry.
// Ports:
//   clk, rst_aL      clock, async active-low reset
//   rename_en        dispatch renames this register (already gated by flush)
//   rename_rob_id    ROB id of the new producer
//   retire_wr        ROB retires a write to this register
//   retire_rob_id    ROB id of the retiring instruction
//   retire_data      committed value
//   flush            mispredict flush, clears the rename
//   data_q, rat_q    current committed data and RAT entry
module arf_rat_entry
    import arf_rat_pkg::*;
(
    input  logic       clk,
    input  logic       rst_aL,
    input  logic       rename_en,
    input  rob_id_t    rename_rob_id,
    input  logic       retire_wr,
    input  rob_id_t    retire_rob_id,
    input  reg_data_t  retire_data,
    input  logic       flush,
    output reg_data_t  data_q,
    output rat_entry_t rat_q
);

    reg_data_t  data_d;
    rat_entry_t rat_d;

    always_comb begin
        data_d = data_q;
        rat_d  = rat_q;

        // Retire is in order, so the committed value is always written.
        if (retire_wr) begin
            data_d = retire_data;
        end

        // Flush beats rename; rename beats the retire clear. A retire whose tag
        // does not match leaves the younger producer's rename in place.
        if (flush) begin
            rat_d = '0;
        end else if (rename_en) begin
            rat_d.renamed = 1'b1;
            rat_d.rob_id  = rename_rob_id;
        end else if (retire_wr && (rat_q.rob_id == retire_rob_id)) begin
            rat_d.renamed = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            data_q <= '0;
            rat_q  <= '0;
        end else begin
            data_q <= data_d;
            rat_q  <= rat_d;
        end
    end

endmodule

// File: rtl/arf_rat.sv
// Architectural register file plus register alias table.
// Ports:
//   clk, rst_aL   clock, async active-low reset
//   bus           arf_rat_if slave: dispatch rename, two source lookups,
//                 ROB retire write and redirect flush
//   arf_state     flat committed register contents, x0 in the low word
// Lookups are combinational and see pre-rename state; a retire that matches
// the current producer tag is bypassed because the ROB frees that id now.
module arf_rat
    import arf_rat_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_aL,
    arf_rat_if.slave                          bus,
    output logic [N_ARF*REG_DATA_WIDTH-1:0]   arf_state
);

    reg_data_t   data_arr [N_ARF];
    rat_entry_t  rat_arr  [N_ARF];
    logic        dispatch_we;
    arf_id_t     src_id   [2];
    src_lookup_t src_res  [2];

    assign dispatch_we = bus.dispatch_fire & bus.dispatch_dst_valid
                       & ~bus.retire_redirect_pc_valid;

    // x0 is hardwired zero and never renamed.
    assign data_arr[0] = '0;
    assign rat_arr[0]  = '0;

    for (genvar i = 1; i < N_ARF; i++) begin : g_entry
        arf_rat_entry u_entry (
            .clk           (clk),
            .rst_aL        (rst_aL),
            .rename_en     (dispatch_we && (bus.dispatch_dst_arf_id == arf_id_t'(i))),
            .rename_rob_id (bus.dispatch_rob_id),
            .retire_wr     (bus.retire && (bus.retire_arf_id == arf_id_t'(i))),
            .retire_rob_id (bus.retire_rob_id),
            .retire_data   (bus.retire_reg_data),
            .flush         (bus.retire_redirect_pc_valid),
            .data_q        (data_arr[i]),
            .rat_q         (rat_arr[i])
        );
    end

    assign src_id[0] = bus.src1_arf_id;
    assign src_id[1] = bus.src2_arf_id;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_res[s] = '0;
            if (src_id[s] != '0) begin
                if (bus.retire && (bus.retire_arf_id == src_id[s])
                    && rat_arr[src_id[s]].renamed
                    && (rat_arr[src_id[s]].rob_id == bus.retire_rob_id)) begin
                    src_res[s].renamed = 1'b0;
                    src_res[s].rob_id  = rat_arr[src_id[s]].rob_id;
                    src_res[s].data    = bus.retire_reg_data;
                end else begin
                    src_res[s].renamed = rat_arr[src_id[s]].renamed;
                    src_res[s].rob_id  = rat_arr[src_id[s]].rob_id;
                    src_res[s].data    = data_arr[src_id[s]];
                end
            end
        end
    end

    assign bus.src1_renamed  = src_res[0].renamed;
    assign bus.src1_rob_id   = src_res[0].rob_id;
    assign bus.src1_reg_data = src_res[0].data;
    assign bus.src2_renamed  = src_res[1].renamed;
    assign bus.src2_rob_id   = src_res[1].rob_id;
    assign bus.src2_reg_data = src_res[1].data;

    always_comb begin
        arf_state = '0;
        for (int i = 0; i < N_ARF; i++) begin
            arf_state[i*REG_DATA_WIDTH +: REG_DATA_WIDTH] = data_arr[i];
        end
    end

endmodule

// File: tb/tb_arf_rat.sv
// Directed, table-driven bench for arf_rat: each vector drives one cycle of
// dispatch/retire/flush, checks the same-cycle lookups before the edge and one
// committed register after it. Reset sequences are hand-written.
module tb_arf_rat;
    import arf_rat_pkg::*;

    logic clk;
    logic rst_aL;
    logic [N_ARF*REG_DATA_WIDTH-1:0] arf_state;

    arf_rat_if bus ();

    arf_rat dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .bus       (bus.slave),
        .arf_state (arf_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fire;
        logic        dv;
        logic [4:0]  dst;
        logic [4:0]  rob;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        ret;
        logic [4:0]  rrob;
        logic [4:0]  rarf;
        logic [31:0] rdata;
        logic        fl;
        logic        e1r;
        logic [4:0]  e1rob;
        logic [31:0] e1d;
        logic        e2r;
        logic [4:0]  e2rob;
        logic [31:0] e2d;
        int          aidx;
        logic [31:0] adata;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic fire, dv, input logic [4:0] dst, rob, s1, s2,
                       input logic ret, input logic [4:0] rrob, rarf, input logic [31:0] rdata,
                       input logic fl,
                       input logic e1r, input logic [4:0] e1rob, input logic [31:0] e1d,
                       input logic e2r, input logic [4:0] e2rob, input logic [31:0] e2d,
                       input int aidx, input logic [31:0] adata);
        vec_t v;
        v.fire = fire; v.dv = dv; v.dst = dst; v.rob = rob; v.s1 = s1; v.s2 = s2;
        v.ret = ret; v.rrob = rrob; v.rarf = rarf; v.rdata = rdata; v.fl = fl;
        v.e1r = e1r; v.e1rob = e1rob; v.e1d = e1d;
        v.e2r = e2r; v.e2rob = e2rob; v.e2d = e2d;
        v.aidx = aidx; v.adata = adata;
        vecs.push_back(v);
    endtask

    task automatic drive_idle(input logic [4:0] s1, input logic [4:0] s2);
        bus.dispatch_fire = 1'b0; bus.dispatch_dst_valid = 1'b0;
        bus.dispatch_dst_arf_id = '0; bus.dispatch_rob_id = '0;
        bus.src1_arf_id = s1; bus.src2_arf_id = s2;
        bus.retire = 1'b0; bus.retire_rob_id = '0; bus.retire_arf_id = '0;
        bus.retire_reg_data = '0; bus.retire_redirect_pc_valid = 1'b0;
    endtask

    function automatic logic [31:0] arf_word(input int idx);
        return arf_state[idx*REG_DATA_WIDTH +: REG_DATA_WIDTH];
    endfunction

    initial begin
        //   fire dv dst rob  s1 s2  ret rrob rarf rdata         fl  e1r e1rob e1d           e2r e2rob e2d           aidx adata
        add(0, 0, 0,  0,   3, 0,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        3,  32'h0);
        add(1, 1, 5,  2,   5, 5,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        5,  32'h0);
        add(0, 0, 0,  0,   5, 3,  0, 0,  0,  32'h0,        0,  1, 2,  32'h0,        0, 0,  32'h0,        5,  32'h0);
        add(0, 0, 0,  0,   5, 5,  1, 2,  5,  32'hDEADBEEF, 0,  0, 0,  32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 5,  32'hDEADBEEF);
        add(0, 0, 0,  0,   5, 0,  0, 0,  0,  32'h0,        0,  0, 0,  32'hDEADBEEF, 0, 0,  32'h0,        5,  32'hDEADBEEF);
        add(1, 1, 7,  1,   7, 0,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        7,  32'h0);
        add(1, 1, 7,  4,   7, 0,  0, 0,  0,  32'h0,        0,  1, 1,  32'h0,        0, 0,  32'h0,        7,  32'h0);
        add(0, 0, 0,  0,   7, 5,  1, 1,  7,  32'h11,       0,  1, 4,  32'h0,        0, 0,  32'hDEADBEEF, 7,  32'h11);
        add(0, 0, 0,  0,   7, 7,  0, 0,  0,  32'h0,        0,  1, 4,  32'h11,       1, 4,  32'h11,       7,  32'h11);
        add(1, 1, 9,  3,   9, 0,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        9,  32'h0);
        add(1, 1, 9,  6,   9, 9,  1, 3,  9,  32'h22,       0,  0, 0,  32'h22,       0, 0,  32'h22,       9,  32'h22);
        add(0, 0, 0,  0,   9, 7,  0, 0,  0,  32'h0,        0,  1, 6,  32'h22,       1, 4,  32'h11,       9,  32'h22);
        add(1, 1, 1,  7,   1, 0,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        1,  32'h0);
        add(1, 1, 2,  8,   1, 2,  0, 0,  0,  32'h0,        0,  1, 7,  32'h0,        0, 0,  32'h0,        2,  32'h0);
        add(1, 1, 31, 9,   1, 2,  0, 0,  0,  32'h0,        0,  1, 7,  32'h0,        1, 8,  32'h0,        31, 32'h0);
        add(1, 1, 4,  10,  31, 4, 0, 0,  0,  32'h0,        1,  1, 9,  32'h0,        0, 0,  32'h0,        4,  32'h0);
        add(0, 0, 0,  0,   1, 31, 0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        1,  32'h0);
        add(0, 0, 0,  0,   7, 9,  0, 0,  0,  32'h0,        0,  0, 0,  32'h11,       0, 0,  32'h22,       7,  32'h11);
        add(0, 0, 0,  0,   4, 2,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        5,  32'hDEADBEEF);
        add(1, 1, 0,  5,   0, 0,  1, 5,  0,  32'h55,       0,  0, 0,  32'h0,        0, 0,  32'h0,        0,  32'h0);
        add(0, 0, 0,  0,   0, 4,  0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        0,  32'h0);
        add(0, 0, 0,  0,   12, 0, 1, 0,  12, 32'h33,       1,  0, 0,  32'h0,        0, 0,  32'h0,        12, 32'h33);
        add(0, 0, 0,  0,   12, 0, 0, 0,  0,  32'h0,        0,  0, 0,  32'h33,       0, 0,  32'h0,        12, 32'h33);
        add(1, 0, 13, 3,   13, 0, 0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        13, 32'h0);
        add(0, 0, 0,  0,   13, 0, 0, 0,  0,  32'h0,        0,  0, 0,  32'h0,        0, 0,  32'h0,        13, 32'h0);

        rst_aL = 1'b0;
        drive_idle(5'd3, 5'd0);
        #1;
        total++;
        if (arf_state === '0) passed++;
        else $display("FAIL reset_arf_state: got nonzero 0x%0h expected 0", arf_state);
        chk("reset_s1_renamed", 32'(bus.src1_renamed), 32'h0);
        chk("reset_s1_rob_id",  32'(bus.src1_rob_id),  32'h0);
        chk("reset_s1_data",    bus.src1_reg_data,     32'h0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_aL = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            bus.dispatch_fire            = vecs[k].fire;
            bus.dispatch_dst_valid       = vecs[k].dv;
            bus.dispatch_dst_arf_id      = vecs[k].dst;
            bus.dispatch_rob_id          = vecs[k].rob;
            bus.src1_arf_id              = vecs[k].s1;
            bus.src2_arf_id              = vecs[k].s2;
            bus.retire                   = vecs[k].ret;
            bus.retire_rob_id            = vecs[k].rrob;
            bus.retire_arf_id            = vecs[k].rarf;
            bus.retire_reg_data          = vecs[k].rdata;
            bus.retire_redirect_pc_valid = vecs[k].fl;
            #2;
            chk($sformatf("v%0d_s1_renamed", k), 32'(bus.src1_renamed), 32'(vecs[k].e1r));
            if (vecs[k].e1r || vecs[k].s1 == 5'd0)
                chk($sformatf("v%0d_s1_rob_id", k), 32'(bus.src1_rob_id), 32'(vecs[k].e1rob));
            chk($sformatf("v%0d_s1_data", k), bus.src1_reg_data, vecs[k].e1d);
            chk($sformatf("v%0d_s2_renamed", k), 32'(bus.src2_renamed), 32'(vecs[k].e2r));
            if (vecs[k].e2r || vecs[k].s2 == 5'd0)
                chk($sformatf("v%0d_s2_rob_id", k), 32'(bus.src2_rob_id), 32'(vecs[k].e2rob));
            chk($sformatf("v%0d_s2_data", k), bus.src2_reg_data, vecs[k].e2d);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_arf_x%0d", k, vecs[k].aidx), arf_word(vecs[k].aidx), vecs[k].adata);
        end

        // Mid-operation async reset: state clears immediately, rename during reset ignored.
        drive_idle(5'd7, 5'd9);
        #2;
        rst_aL = 1'b0;
        #1;
        total++;
        if (arf_state === '0) passed++;
        else $display("FAIL midreset_arf_state: got nonzero 0x%0h expected 0", arf_state);
        chk("midreset_s1_data",    bus.src1_reg_data,     32'h0);
        chk("midreset_s2_data",    bus.src2_reg_data,     32'h0);
        chk("midreset_s1_renamed", 32'(bus.src1_renamed), 32'h0);
        bus.dispatch_fire = 1'b1; bus.dispatch_dst_valid = 1'b1;
        bus.dispatch_dst_arf_id = 5'd6; bus.dispatch_rob_id = 5'd2;
        bus.src1_arf_id = 5'd6;
        @(posedge clk);
        #1;
        chk("inreset_s1_renamed", 32'(bus.src1_renamed), 32'h0);
        bus.dispatch_fire = 1'b0;
        #2 rst_aL = 1'b1;
        @(posedge clk);
        #1;
        chk("postreset_s1_renamed", 32'(bus.src1_renamed), 32'h0);
        bus.dispatch_fire = 1'b1;
        @(posedge clk);
        #1;
        bus.dispatch_fire = 1'b0;
        #1;
        chk("postreset_rename_renamed", 32'(bus.src1_renamed), 32'h1);
        chk("postreset_rename_rob_id",  32'(bus.src1_rob_id),  32'h2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
